// File: rtl/cam_controller.sv
// CAM sequencer/arbiter: round-robin grant, one op in flight, per-entry valid tracking, tagged response.
// Optional CAM_CTRL_STATS_EN adds saturating search/hit counters.
module cam_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int DEPTH       = 1 << ADDR_WIDTH,
  parameter int NUM_REQ     = 2,
  parameter int ID_WIDTH    = $clog2(NUM_REQ),
  parameter int CAM_LATENCY = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*2-1:0]          req_op_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_index_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic                          read_o,
  output logic                          write_o,
  output logic                          search_o,
  output logic [ADDR_WIDTH-1:0]         read_index_o,
  output logic [ADDR_WIDTH-1:0]         write_index_o,
  output logic [DATA_WIDTH-1:0]         write_data_o,
  output logic [DATA_WIDTH-1:0]         search_data_o,
  input  logic [DATA_WIDTH-1:0]         read_data_i,
  input  logic [DEPTH-1:0]              match_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [ID_WIDTH-1:0]           resp_id_o,
  output logic                          resp_hit_o,
  output logic [ADDR_WIDTH-1:0]         resp_index_o,
  output logic [DATA_WIDTH-1:0]         resp_data_o
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]                   search_cnt_o,
  output logic [15:0]                   hit_cnt_o
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;

  localparam int CNT_W = (CAM_LATENCY > 1) ? $clog2(CAM_LATENCY) : 1;

  logic [1:0]            state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   cand;
  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [1:0]            cur_op;
  logic [ADDR_WIDTH-1:0] cur_index;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [DEPTH-1:0]      valid;
  logic                  pre_valid;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  hit_q;
  logic [ADDR_WIDTH-1:0] index_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DEPTH-1:0]      masked;
  logic                  search_hit;
  logic [ADDR_WIDTH-1:0] search_idx;
  logic                  found;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_WIDTH'((32'(rr_ptr) + i) % NUM_REQ);
      if (!grant_valid && req_valid_i[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

  // Only live entries may match; the lowest live match wins.
  always_comb begin
    masked     = match_i & valid;
    search_hit = |masked;
    search_idx = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (masked[i] && !found) begin
        search_idx = ADDR_WIDTH'(i);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      cur_op    <= '0;
      cur_index <= '0;
      cur_data  <= '0;
      valid     <= '0;
      pre_valid <= 1'b0;
      wait_cnt  <= '0;
      hit_q     <= 1'b0;
      index_q   <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_id    <= grant;
            cur_op    <= req_op_i[2*grant +: 2];
            cur_index <= req_index_i[ADDR_WIDTH*grant +: ADDR_WIDTH];
            cur_data  <= req_data_i[DATA_WIDTH*grant +: DATA_WIDTH];
            rr_ptr    <= (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Sample before the update so INVAL can report the prior state.
          pre_valid <= valid[cur_index];
          if (cur_op == OP_WRITE) valid[cur_index] <= 1'b1;
          if (cur_op == OP_INVAL) valid[cur_index] <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(CAM_LATENCY - 1)) begin
            index_q <= cur_index;
            data_q  <= '0;
            case (cur_op)
              OP_READ: begin
                hit_q  <= pre_valid;
                data_q <= read_data_i;
              end
              OP_WRITE: hit_q <= 1'b1;
              OP_SEARCH: begin
                hit_q   <= search_hit;
                index_q <= search_idx;
              end
              default: hit_q <= pre_valid;
            endcase
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          if (resp_ready_i) state <= IDLE;
        end
      endcase
    end
  end

`ifdef CAM_CTRL_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      search_cnt_o <= '0;
      hit_cnt_o    <= '0;
    end else if (state == RESP && resp_ready_i && cur_op == OP_SEARCH) begin
      if (search_cnt_o != 16'hFFFF) search_cnt_o <= search_cnt_o + 16'd1;
      if (hit_q && hit_cnt_o != 16'hFFFF) hit_cnt_o <= hit_cnt_o + 16'd1;
    end
  end
`endif

  assign req_ready_o = (state == IDLE && grant_valid && !reset_i) ?
                       (NUM_REQ'(1) << grant) : '0;

  assign read_o        = (state == ISSUE) && (cur_op == OP_READ);
  assign write_o       = (state == ISSUE) && (cur_op == OP_WRITE);
  assign search_o      = (state == ISSUE) && (cur_op == OP_SEARCH);
  assign read_index_o  = read_o   ? cur_index : '0;
  assign write_index_o = write_o  ? cur_index : '0;
  assign write_data_o  = write_o  ? cur_data  : '0;
  assign search_data_o = search_o ? cur_data  : '0;

  assign resp_valid_o = (state == RESP);
  assign resp_id_o    = resp_valid_o ? cur_id  : '0;
  assign resp_hit_o   = resp_valid_o ? hit_q   : 1'b0;
  assign resp_index_o = resp_valid_o ? index_q : '0;
  assign resp_data_o  = resp_valid_o ? data_q  : '0;

endmodule
